// File: rtl/fir_practice_if.sv
// Sample bus between the CORDIC tone source and the FIR smoothing filter.
// The filter paces the source: the source drives NOISE_SIGNAL, the filter
// reports the capture cycle and returns filtered samples.
interface fir_practice_if #(
    parameter int OUT_W = 16
);
    logic signed [OUT_W-1:0] NOISE_SIGNAL;
    logic                    SAMPLE_STROBE;
    logic signed [OUT_W-1:0] FILTERED_SIGNAL;
    logic                    FILTERED_VALID;

    // Sample source / result consumer side
    modport master (
        output NOISE_SIGNAL,
        input  SAMPLE_STROBE,
        input  FILTERED_SIGNAL,
        input  FILTERED_VALID
    );

    // Filter side
    modport slave (
        input  NOISE_SIGNAL,
        output SAMPLE_STROBE,
        output FILTERED_SIGNAL,
        output FILTERED_VALID
    );
endinterface

// File: rtl/fir_practice.sv
// 9-tap symmetric low-pass FIR in the cordic_clk domain.
// Takes one sample every SAMPLE_DIV clocks, Q15 coefficients, round half up,
// saturating 16-bit signed output registered one clock after the shift.
module fir_practice #(
    parameter int SAMPLE_DIV = 5,
    parameter int OUT_W      = 16,
    parameter int COEF_W     = 16
) (
    input  logic          cordic_clk,
    input  logic          RSTN,
    fir_practice_if.slave bus
);
    localparam int TAPS   = 9;
    localparam int HALF   = 4;              // index of the centre tap
    localparam int CNT_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int ACC_W  = 36;
    localparam int PRE_W  = OUT_W + 1;      // symmetric pair sum needs one extra bit
    localparam int FRAC   = 15;
    localparam int STAGES = 1;

    // Unique half of the symmetric impulse response; h[k] == h[8-k]
    localparam logic signed [COEF_W-1:0] H [0:HALF] = '{
        16'sd306, 16'sd1560, 16'sd4011, 16'sd6623, 16'sd7768
    };

    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = -Y_MAX - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] RND   = ACC_W'(2**(FRAC-1));

    logic [CNT_W-1:0]        r_cnt;
    logic                    w_strobe;
    logic signed [OUT_W-1:0] r_x [0:TAPS-1];
    logic signed [PRE_W-1:0] w_pre  [0:HALF];
    logic signed [ACC_W-1:0] w_prod [0:HALF];
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_rnd;
    logic signed [ACC_W-1:0] w_shr;
    logic signed [OUT_W-1:0] w_y;
    logic signed [OUT_W-1:0] r_y;
    logic [STAGES:0]         r_vld_pipe;

    // Strobe is decoded straight from the counter; counter is 0 in reset so no
    // strobe can leak out while RSTN is low.
    assign w_strobe          = (r_cnt == CNT_W'(SAMPLE_DIV - 1));
    assign bus.SAMPLE_STROBE = w_strobe;

    // Sample-rate divider: 0..SAMPLE_DIV-1, wrapping on the strobe cycle
    always_ff @(posedge cordic_clk or negedge RSTN) begin
        if (!RSTN)         r_cnt <= '0;
        else if (w_strobe) r_cnt <= '0;
        else               r_cnt <= r_cnt + CNT_W'(1);
    end

    // Delay line: shifts only on strobe edges, input ignored otherwise
    always_ff @(posedge cordic_clk or negedge RSTN) begin
        if (!RSTN) begin
            for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
        end else if (w_strobe) begin
            r_x[0] <= bus.NOISE_SIGNAL;
            for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
        end
    end

    // Pre-add mirrored taps so only five multipliers are needed; exact, since
    // the pair sum is carried at full PRE_W width.
    genvar g;
    generate
        for (g = 0; g < HALF; g++) begin : g_pair
            assign w_pre[g] = PRE_W'(r_x[g]) + PRE_W'(r_x[TAPS-1-g]);
        end
        assign w_pre[HALF] = PRE_W'(r_x[HALF]);

        for (g = 0; g <= HALF; g++) begin : g_mul
            assign w_prod[g] = ACC_W'(w_pre[g]) * ACC_W'(H[g]);
        end
    endgenerate

    // Full-precision accumulation of the five partial products
    always_comb begin
        w_acc = '0;
        for (int k = 0; k <= HALF; k++) w_acc = w_acc + w_prod[k];
    end

    assign w_rnd = w_acc + RND;
    assign w_shr = w_rnd >>> FRAC;

    // Clamp the rounded Q15 result to the output range
    always_comb begin
        w_y = w_shr[OUT_W-1:0];
        if (w_shr > Y_MAX)      w_y = Y_MAX[OUT_W-1:0];
        else if (w_shr < Y_MIN) w_y = Y_MIN[OUT_W-1:0];
    end

    // Valid pipeline: stage 0 marks the shift edge, stage 1 marks the output load
    always_ff @(posedge cordic_clk or negedge RSTN) begin
        if (!RSTN) r_vld_pipe <= '0;
        else       r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_strobe};
    end

    // Output register: loads from the freshly shifted delay line, holds otherwise
    always_ff @(posedge cordic_clk or negedge RSTN) begin
        if (!RSTN)              r_y <= '0;
        else if (r_vld_pipe[0]) r_y <= w_y;
    end

    assign bus.FILTERED_SIGNAL = r_y;
    assign bus.FILTERED_VALID  = r_vld_pipe[STAGES];
endmodule

// File: tb/tb_fir_practice.sv
// Directed bench for fir_practice: reset, strobe cadence, impulse response,
// input hold between strobes, DC gain / saturation, two-tone and mid-run reset.
module tb_fir_practice;
    logic cordic_clk = 1'b0;
    logic RSTN;
    int   n_tests = 0;
    int   n_fail  = 0;

    fir_practice_if #(.OUT_W(16)) bus ();

    fir_practice #(.SAMPLE_DIV(5), .OUT_W(16), .COEF_W(16)) dut (
        .cordic_clk (cordic_clk),
        .RSTN       (RSTN),
        .bus        (bus)
    );

    always #5 cordic_clk = ~cordic_clk;

    localparam logic signed [15:0] HC [0:8] = '{
        16'sd306, 16'sd1560, 16'sd4011, 16'sd6623, 16'sd7768,
        16'sd6623, 16'sd4011, 16'sd1560, 16'sd306
    };

    // Waits (bounded) for a strobe at a negedge, presents v, returns the output
    // that appears with the next FILTERED_VALID. Junk is driven off-strobe.
    task automatic send(input logic signed [15:0] v, output logic signed [15:0] y);
        int t;
        t = 0;
        y = '0;
        while (bus.SAMPLE_STROBE !== 1'b1 && t < 20) begin
            @(negedge cordic_clk);
            t++;
        end
        n_tests++;
        if (bus.SAMPLE_STROBE !== 1'b1) begin
            n_fail++;
            $display("FAIL strobe_wait: no strobe after %0d cycles, need one within 20", t);
        end else begin
            bus.NOISE_SIGNAL = v;
            @(negedge cordic_clk);
            bus.NOISE_SIGNAL = 16'sh5A5A;
            @(negedge cordic_clk);
            n_tests++;
            if (bus.FILTERED_VALID !== 1'b1) begin
                n_fail++;
                $display("FAIL valid_pulse: FILTERED_VALID=%b, need 1", bus.FILTERED_VALID);
            end
            y = bus.FILTERED_SIGNAL;
        end
    endtask

    // After RSTN release at a negedge: strobe visible after 4th edge (captured on
    // the 5th), then every 5 edges. Leaves the bench at a negedge with strobe high.
    task automatic check_first_strobe(input string name);
        int n;
        n = 0;
        do begin @(posedge cordic_clk); #1; n++; end
        while (bus.SAMPLE_STROBE !== 1'b1 && n < 20);
        n_tests++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL %s_first: strobe after %0d edges, need 4", name, n);
        end
        n = 0;
        do begin @(posedge cordic_clk); #1; n++; end
        while (bus.SAMPLE_STROBE !== 1'b1 && n < 20);
        n_tests++;
        if (n != 5) begin
            n_fail++;
            $display("FAIL %s_period: strobe after %0d edges, need 5", name, n);
        end
        @(negedge cordic_clk);
    endtask

    task automatic test_reset();
        RSTN = 1'b1;
        bus.NOISE_SIGNAL = '0;
        #3 RSTN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge cordic_clk);
            bus.NOISE_SIGNAL = 16'($urandom);
            n_tests++;
            if (bus.SAMPLE_STROBE !== 1'b0 || bus.FILTERED_VALID !== 1'b0 ||
                bus.FILTERED_SIGNAL !== 16'sd0) begin
                n_fail++;
                $display("FAIL reset_hold: strobe=%b valid=%b out=%0d, need 0/0/0",
                         bus.SAMPLE_STROBE, bus.FILTERED_VALID, bus.FILTERED_SIGNAL);
            end
        end
        bus.NOISE_SIGNAL = '0;
        @(negedge cordic_clk);
        RSTN = 1'b1;
        check_first_strobe("reset");
    endtask

    task automatic test_impulse(input string name);
        logic signed [15:0] y;
        send(16'sd32767, y);
        n_tests++;
        if (y !== HC[0]) begin
            n_fail++;
            $display("FAIL %s_tap0: got %0d, need %0d", name, y, HC[0]);
        end
        for (int i = 1; i < 10; i++) begin
            logic signed [15:0] e;
            e = (i < 9) ? HC[i] : 16'sd0;
            send(16'sd0, y);
            n_tests++;
            if (y !== e) begin
                n_fail++;
                $display("FAIL %s_tap%0d: got %0d, need %0d", name, i, y, e);
            end
        end
    endtask

    task automatic test_hold();
        logic signed [15:0] y;
        send(16'sd32767, y);
        for (int i = 0; i < 2; i++) begin
            @(negedge cordic_clk);
            bus.NOISE_SIGNAL = 16'($urandom);
            n_tests++;
            if (bus.FILTERED_SIGNAL !== 16'sd306 || bus.FILTERED_VALID !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_out: out=%0d valid=%b, need 306/0",
                         bus.FILTERED_SIGNAL, bus.FILTERED_VALID);
            end
        end
        send(16'sd0, y);
        n_tests++;
        if (y !== 16'sd1560) begin
            n_fail++;
            $display("FAIL hold_line: got %0d, need 1560", y);
        end
        for (int i = 0; i < 8; i++) send(16'sd0, y);
    endtask

    task automatic test_dc(input string name, input logic signed [15:0] v,
                           input bit chk_first, input logic signed [15:0] first_exp);
        logic signed [15:0] y;
        for (int i = 0; i < 10; i++) begin
            send(v, y);
            if (i == 0 && chk_first) begin
                n_tests++;
                if (y !== first_exp) begin
                    n_fail++;
                    $display("FAIL %s_first: got %0d, need %0d", name, y, first_exp);
                end
            end
            if (i >= 8) begin
                n_tests++;
                if (y !== v) begin
                    n_fail++;
                    $display("FAIL %s_settle%0d: got %0d, need %0d", name, i + 1, y, v);
                end
            end
        end
    endtask

    task automatic test_tones_midrun_reset();
        logic signed [15:0] y;
        int  v, ymax, ymin;
        real pi;
        pi   = 3.14159265358979;
        ymax = -40000;
        ymin = 40000;
        for (int n = 0; n < 80; n++) begin
            v = int'(16383.0 * ($sin(2.0 * pi * 0.02 * n) + $sin(2.0 * pi * 0.3 * n)));
            send(16'(v), y);
            if (n >= 12) begin
                if (int'(y) > ymax) ymax = int'(y);
                if (int'(y) < ymin) ymin = int'(y);
            end
        end
        n_tests++;
        if (ymax < 15800 || ymax > 16200) begin
            n_fail++;
            $display("FAIL tone_peak: got %0d, need 15800..16200", ymax);
        end
        n_tests++;
        if (ymin > -15800 || ymin < -16200) begin
            n_fail++;
            $display("FAIL tone_trough: got %0d, need -16200..-15800", ymin);
        end
        // Asynchronous reset in the middle of a clock phase
        @(negedge cordic_clk);
        #2 RSTN = 1'b0;
        #1;
        n_tests++;
        if (bus.FILTERED_SIGNAL !== 16'sd0 || bus.FILTERED_VALID !== 1'b0 ||
            bus.SAMPLE_STROBE !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_clear: out=%0d valid=%b strobe=%b, need 0/0/0",
                     bus.FILTERED_SIGNAL, bus.FILTERED_VALID, bus.SAMPLE_STROBE);
        end
        bus.NOISE_SIGNAL = '0;
        repeat (3) @(negedge cordic_clk);
        RSTN = 1'b1;
        check_first_strobe("restart");
        test_impulse("restart_imp");
    endtask

    initial begin
        bus.NOISE_SIGNAL = '0;
        test_reset();
        test_impulse("impulse");
        test_hold();
        test_dc("dc_10000", 16'sd10000, 1'b1, 16'sd93);
        test_dc("dc_neg", -16'sd32768, 1'b0, 16'sd0);
        test_dc("dc_pos", 16'sd32767, 1'b0, 16'sd0);
        test_tones_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
